sram_sequencer: RTL and testbench

SRAM_SEQUENCER -- requirements
Module: sram_sequencer

---
 rtl/sram_sequencer.sv | 161 ++++++++++++++++
 tb/tb_sram_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_sequencer.sv
// sram_sequencer: arbitrates a host write port and a timed playback reader onto
// one single-port 12x12 SRAM.
//
// Parameters
//   DEPTH       number of valid SRAM entries (addresses 0..DEPTH-1)
//   STEP_CYCLES clock cycles per playback step (3..65535)
//
// Ports
//   CLK, RST          clock, synchronous active-low reset
//   WrReq/WrAddr/WrData  host write request (level, held until WrAck)
//   WrAck, WrErr      one-cycle completion pulse; WrErr flags an out-of-range address
//   Play, Rewind      playback run/pause level, one-cycle rewind-to-0 pulse
//   MemAddress/MemRW/MemDin/MemDout  SRAM port (MemDout combinational from MemAddress)
//   Step              address of the next entry to play
//   StepData/StepValid  last entry read, with a one-cycle update pulse
//   Busy              FSM is in WRITE or READ
module sram_sequencer #(
    parameter int unsigned DEPTH       = 12,
    parameter int unsigned STEP_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        WrReq,
    input  logic [3:0]  WrAddr,
    input  logic [11:0] WrData,
    input  logic        Play,
    input  logic        Rewind,
    input  logic [11:0] MemDout,
    output logic [3:0]  MemAddress,
    output logic        MemRW,
    output logic [11:0] MemDin,
    output logic        WrAck,
    output logic        WrErr,
    output logic [3:0]  Step,
    output logic [11:0] StepData,
    output logic        StepValid,
    output logic        Busy
);

    typedef enum logic [1:0] {
        st_idle,
        st_write,
        st_read
    } state_t;

    state_t      state, state_next;
    logic [15:0] tick_cnt;
    logic        step_due;
    logic        play_q;
    logic [3:0]  wr_addr;
    logic [11:0] wr_data;
    logic [3:0]  step;
    logic [11:0] step_data;
    logic        step_valid;
    logic        wr_ack;
    logic        wr_err;
    logic        wr_addr_ok;
    logic        tick_last;
    logic        step_last;

    assign wr_addr_ok = 32'(wr_addr) < DEPTH;
    assign tick_last  = tick_cnt == 16'(STEP_CYCLES - 1);
    assign step_last  = step == 4'(DEPTH - 1);

    // Next state. A playback step always wins over a pending write. While
    // WrAck is high the requester has not yet dropped WrReq, so the still-high
    // level must not start a second write.
    always_comb begin
        state_next = state;
        case (state)
            st_idle: begin
                if (step_due) begin
                    state_next = st_read;
                end else if (WrReq && !wr_ack) begin
                    state_next = st_write;
                end
            end
            st_write: state_next = st_idle;
            st_read:  state_next = st_idle;
            default:  state_next = st_idle;
        endcase
    end

    // SRAM port. The write enable is gated with RST so a reset landing on a
    // WRITE cycle never commits data.
    always_comb begin
        MemAddress = step;
        MemRW      = 1'b0;
        MemDin     = 12'h000;
        if (state == st_write) begin
            MemAddress = wr_addr;
            MemDin     = wr_data;
            MemRW      = wr_addr_ok && RST;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= st_idle;
            tick_cnt   <= 16'd0;
            step_due   <= 1'b0;
            play_q     <= 1'b0;
            wr_addr    <= 4'd0;
            wr_data    <= 12'h000;
            step       <= 4'd0;
            step_data  <= 12'h000;
            step_valid <= 1'b0;
            wr_ack     <= 1'b0;
            wr_err     <= 1'b0;
        end else begin
            state      <= state_next;
            play_q     <= Play;
            wr_ack     <= state == st_write;
            wr_err     <= (state == st_write) && !wr_addr_ok;
            step_valid <= state == st_read;

            if (state == st_idle && state_next == st_write) begin
                wr_addr <= WrAddr;
                wr_data <= WrData;
            end

            if (state == st_read) begin
                step_data <= MemDout;
            end

            // Rewind overrides the post-read increment.
            if (Rewind) begin
                step <= 4'd0;
            end else if (state == st_read) begin
                step <= step_last ? 4'd0 : step + 4'd1;
            end

            // Tick timer. Setting step_due takes priority over the READ-exit
            // clear; being a single flag, a set while set cannot queue a
            // second read.
            if (!Play) begin
                tick_cnt <= 16'd0;
                step_due <= 1'b0;
            end else if (!play_q) begin
                tick_cnt <= 16'd0;
                step_due <= 1'b1;
            end else if (tick_last) begin
                tick_cnt <= 16'd0;
                step_due <= 1'b1;
            end else begin
                tick_cnt <= tick_cnt + 16'd1;
                if (state == st_read) begin
                    step_due <= 1'b0;
                end
            end
        end
    end

    assign WrAck     = wr_ack;
    assign WrErr     = wr_err;
    assign Step      = step;
    assign StepData  = step_data;
    assign StepValid = step_valid;
    assign Busy      = state != st_idle;

endmodule

// File: tb/tb_sram_sequencer.sv
// Directed bench for sram_sequencer with a behavioural 12-entry SRAM.
module tb_sram_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        WrReq;
    logic [3:0]  WrAddr;
    logic [11:0] WrData;
    logic        Play;
    logic        Rewind;
    logic [11:0] MemDout;
    logic [3:0]  MemAddress;
    logic        MemRW;
    logic [11:0] MemDin;
    logic        WrAck;
    logic        WrErr;
    logic [3:0]  Step;
    logic [11:0] StepData;
    logic        StepValid;
    logic        Busy;

    int checks   = 0;
    int failures = 0;

    logic [11:0] mem     [0:15];
    logic [11:0] exp_mem [0:15];

    always #5 CLK = ~CLK;

    sram_sequencer #(
        .DEPTH       (12),
        .STEP_CYCLES (4)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .WrReq      (WrReq),
        .WrAddr     (WrAddr),
        .WrData     (WrData),
        .Play       (Play),
        .Rewind     (Rewind),
        .MemDout    (MemDout),
        .MemAddress (MemAddress),
        .MemRW      (MemRW),
        .MemDin     (MemDin),
        .WrAck      (WrAck),
        .WrErr      (WrErr),
        .Step       (Step),
        .StepData   (StepData),
        .StepValid  (StepValid),
        .Busy       (Busy)
    );

    // SRAM model: only the first 12 entries exist.
    always @(posedge CLK) begin
        if (MemRW && MemAddress < 4'd12) mem[MemAddress] <= MemDin;
    end
    assign MemDout = mem[MemAddress];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; holds WrReq for at most 3 cycles.
    task automatic do_write(input logic [3:0] a, input logic [11:0] d, input logic err);
        int   rw_cnt;
        logic acked;
        logic e;
        rw_cnt = 0;
        acked  = 1'b0;
        e      = 1'b0;
        WrReq  = 1'b1;
        WrAddr = a;
        WrData = d;
        for (int i = 0; i < 3 && !acked; i++) begin
            @(negedge CLK);
            if (MemRW) rw_cnt++;
            if (WrAck) begin
                acked = 1'b1;
                e     = WrErr;
            end
        end
        WrReq = 1'b0;
        check("wr_ack_seen", 32'(acked), 32'd1);
        check("wr_err", 32'(e), 32'(err));
        check("memrw_cycles", 32'(rw_cnt), err ? 32'd0 : 32'd1);
        if (!err) exp_mem[a] = d;
    endtask

    // Waits for the next StepValid pulse and checks its latency and payload.
    task automatic wait_step(input int exp_lat, input logic [11:0] exp_d, input logic [3:0] exp_s);
        int   n;
        logic got;
        n   = 0;
        got = 1'b0;
        while (!got && n < 8) begin
            @(negedge CLK);
            n++;
            if (StepValid) got = 1'b1;
        end
        check("step_valid_seen", 32'(got), 32'd1);
        check("step_latency", 32'(n), 32'(exp_lat));
        check("step_data", 32'(StepData), 32'(exp_d));
        check("step_addr", 32'(Step), 32'(exp_s));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        int sv_cnt;
        RST    = 1'b0;
        WrReq  = 1'b0;
        WrAddr = 4'd0;
        WrData = 12'h000;
        Play   = 1'b0;
        Rewind = 1'b0;
        for (int i = 0; i < 16; i++) exp_mem[i] = 12'h000;
        for (int i = 0; i < 16; i++) mem[i] = 12'h000;

        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_step", 32'(Step), 32'd0);
        check("rst_step_data", 32'(StepData), 32'd0);
        check("rst_step_valid", 32'(StepValid), 32'd0);
        check("rst_wr_ack", 32'(WrAck), 32'd0);
        check("rst_wr_err", 32'(WrErr), 32'd0);
        check("rst_memrw", 32'(MemRW), 32'd0);
        check("rst_memdin", 32'(MemDin), 32'd0);
        RST = 1'b1;
        @(negedge CLK);

        // Write sweep
        for (int a = 0; a < 12; a++) do_write(4'(a), 12'h100 + 12'(a), 1'b0);
        @(negedge CLK);

        // Playback: first step immediate, then every 4 cycles, wrapping after 11
        Play = 1'b1;
        wait_step(3, 12'h100, 4'd1);
        for (int k = 1; k <= 18; k++) wait_step(4, 12'h100 + 12'(k % 12), 4'((k + 1) % 12));

        // Step is 7: rewind from IDLE
        Rewind = 1'b1;
        @(negedge CLK);
        Rewind = 1'b0;
        check("rewind_step", 32'(Step), 32'd0);
        wait_step(3, 12'h100, 4'd1);

        // Rewind coinciding with READ exit: rewind wins
        repeat (3) @(negedge CLK);
        check("read_busy", 32'(Busy), 32'd1);
        check("read_addr", 32'(MemAddress), 32'd1);
        check("read_memrw", 32'(MemRW), 32'd0);
        Rewind = 1'b1;
        @(negedge CLK);
        Rewind = 1'b0;
        check("rw_win_valid", 32'(StepValid), 32'd1);
        check("rw_win_data", 32'(StepData), 32'h101);
        check("rw_win_step", 32'(Step), 32'd0);

        // Play dropped mid-READ: read completes, then nothing more
        repeat (3) @(negedge CLK);
        Play = 1'b0;
        @(negedge CLK);
        check("pause_valid", 32'(StepValid), 32'd1);
        check("pause_data", 32'(StepData), 32'h100);
        check("pause_step", 32'(Step), 32'd1);
        sv_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (StepValid) sv_cnt++;
        end
        check("paused_no_steps", 32'(sv_cnt), 32'd0);
        Rewind = 1'b1;
        @(negedge CLK);
        Rewind = 1'b0;

        // Collision: write request while step_due is set
        Play = 1'b1;
        @(negedge CLK);
        WrReq  = 1'b1;
        WrAddr = 4'd5;
        WrData = 12'hABC;
        @(negedge CLK);
        check("coll_read_busy", 32'(Busy), 32'd1);
        check("coll_read_memrw", 32'(MemRW), 32'd0);
        @(negedge CLK);
        check("coll_step_valid", 32'(StepValid), 32'd1);
        check("coll_step_data", 32'(StepData), 32'h100);
        check("coll_no_ack_yet", 32'(WrAck), 32'd0);
        @(negedge CLK);
        check("coll_write_memrw", 32'(MemRW), 32'd1);
        check("coll_write_addr", 32'(MemAddress), 32'd5);
        check("coll_write_din", 32'(MemDin), 32'hABC);
        @(negedge CLK);
        check("coll_wr_ack", 32'(WrAck), 32'd1);
        check("coll_wr_err", 32'(WrErr), 32'd0);
        WrReq = 1'b0;
        exp_mem[5] = 12'hABC;
        wait_step(2, 12'h101, 4'd2);
        wait_step(4, 12'h102, 4'd3);
        wait_step(4, 12'h103, 4'd4);
        wait_step(4, 12'h104, 4'd5);
        wait_step(4, 12'hABC, 4'd6);
        Play = 1'b0;
        repeat (2) @(negedge CLK);

        // Out-of-range write
        do_write(4'd13, 12'h555, 1'b1);
        bad = 0;
        for (int i = 0; i < 12; i++) if (mem[i] !== exp_mem[i]) bad++;
        check("mem_contents", 32'(bad), 32'd0);

        // Reset landing on a WRITE cycle
        @(negedge CLK);
        WrReq  = 1'b1;
        WrAddr = 4'd3;
        WrData = 12'hDEF;
        @(negedge CLK);
        check("wr_busy", 32'(Busy), 32'd1);
        RST = 1'b0;
        #1;
        check("rst_write_memrw", 32'(MemRW), 32'd0);
        @(negedge CLK);
        WrReq = 1'b0;
        check("rst2_busy", 32'(Busy), 32'd0);
        check("rst2_step", 32'(Step), 32'd0);
        check("rst2_step_data", 32'(StepData), 32'd0);
        check("rst2_step_valid", 32'(StepValid), 32'd0);
        check("rst2_wr_ack", 32'(WrAck), 32'd0);
        check("rst2_wr_err", 32'(WrErr), 32'd0);
        check("rst2_memrw", 32'(MemRW), 32'd0);
        check("rst2_mem3", 32'(mem[3]), 32'h103);
        RST = 1'b1;
        sv_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (WrAck) sv_cnt++;
        end
        check("dropped_req_no_ack", 32'(sv_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
